// File: rtl/vga_frame_reader.sv
// Pixel-path stage behind the 1024x768 VGA timing generator.
// It fetches an IMG_W x IMG_H image from a double-buffered frame memory, upscales
// it by 2^SHIFT and places it at (X0,Y0) with a BORDER colour around it. It delays
// hsync/vsync so they stay aligned with the fetched RGB, and it swaps the displayed
// buffer only at end of screen, using a req/ack handshake with the image filter.
// Ports:
//   clk, reset          base clock, synchronous active-high reset
//   pix_stb             pipeline advances only on edges where this is high
//   hsync_in/vsync_in   active-low syncs from the timing generator
//   active_in, x, y     active-area flag and pixel coordinates
//   screenend           one-tick end-of-screen marker
//   swap_req/swap_ack   back-buffer ready level / one-clk swap-done pulse
//   buf_sel             buffer currently displayed
//   mem_en/mem_addr     registered read request {buf_sel,row,col}
//   mem_rdata           RGB444 read data, valid MEM_LAT strobes after mem_en
//   hsync_out/vsync_out syncs delayed by MEM_LAT+1 strobes
//   rgb                 RGB444 pixel aligned with the delayed syncs
module vga_frame_reader #(
    parameter int unsigned IMG_W   = 256,
    parameter int unsigned IMG_H   = 256,
    parameter int unsigned SHIFT   = 1,
    parameter int unsigned X0      = 256,
    parameter int unsigned Y0      = 128,
    parameter int unsigned MEM_LAT = 2,
    parameter logic [11:0] BORDER  = 12'h000,
    parameter int unsigned AW      = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_stb,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          active_in,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          screenend,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          buf_sel,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [11:0]   mem_rdata,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic [11:0]   rgb
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned X1 = X0 + (IMG_W << SHIFT);
    localparam int unsigned Y1 = Y0 + (IMG_H << SHIFT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_DROP = 2'd2
    } state_t;

    logic [10:0]        w_x11, w_y11, w_dx, w_dy;
    logic               w_win;
    logic [CW-1:0]      w_col;
    logic [RW-1:0]      w_row;
    logic               w_end;
    logic               w_swap;
    state_t             r_state, w_state_nxt;

    logic               r_mem_en;
    logic [AW-1:0]      r_mem_addr;
    logic               r_buf_sel;
    logic               r_swap_ack;
    logic [MEM_LAT-1:0] r_hs_d, r_vs_d, r_act_d, r_win_d;
    logic               r_hsync, r_vsync;
    logic [11:0]        r_rgb;

    // Window test and image coordinates, in 11-bit unsigned so nothing wraps in
    assign w_x11 = {1'b0, x};
    assign w_y11 = {1'b0, y};
    assign w_dx  = w_x11 - 11'(X0);
    assign w_dy  = w_y11 - 11'(Y0);
    assign w_win = active_in
                 & (w_x11 >= 11'(X0)) & (w_x11 < 11'(X1))
                 & (w_y11 >= 11'(Y0)) & (w_y11 < 11'(Y1));
    assign w_col = CW'(w_dx >> SHIFT);
    assign w_row = RW'(w_dy >> SHIFT);
    assign w_end = screenend & pix_stb;

    // Stage 0: read request; address holds outside the window
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_mem_en <= pix_stb & w_win;
            if (pix_stb && w_win) begin
                r_mem_addr <= AW'({r_buf_sel, w_row, w_col});
            end
        end
    end

    // Delay line for sync/active/win; reset loads idle values to flush the pipe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_d  <= '1;
            r_vs_d  <= '1;
            r_act_d <= '0;
            r_win_d <= '0;
        end else if (pix_stb) begin
            r_hs_d[0]  <= hsync_in;
            r_vs_d[0]  <= vsync_in;
            r_act_d[0] <= active_in;
            r_win_d[0] <= w_win;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                r_hs_d[i]  <= r_hs_d[i-1];
                r_vs_d[i]  <= r_vs_d[i-1];
                r_act_d[i] <= r_act_d[i-1];
                r_win_d[i] <= r_win_d[i-1];
            end
        end
    end

    // Output stage: samples mem_rdata on the MEM_LAT-th strobe after mem_en
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 12'h000;
        end else if (pix_stb) begin
            r_hsync <= r_hs_d[MEM_LAT-1];
            r_vsync <= r_vs_d[MEM_LAT-1];
            if (!r_act_d[MEM_LAT-1]) begin
                r_rgb <= 12'h000;
            end else if (r_win_d[MEM_LAT-1]) begin
                r_rgb <= mem_rdata;
            end else begin
                r_rgb <= BORDER;
            end
        end
    end

    // Swap FSM state register, buffer select and ack pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_buf_sel  <= 1'b0;
            r_swap_ack <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_swap_ack <= w_swap;
            if (w_swap) begin
                r_buf_sel <= ~r_buf_sel;
            end
        end
    end

    // Swap FSM next state; a request arriving with screenend swaps at once,
    // a request dropped while pending is abandoned
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (swap_req) begin
                    if (w_end) begin
                        w_swap      = 1'b1;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_state_nxt = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (!swap_req) begin
                    w_state_nxt = S_IDLE;
                end else if (w_end) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (!swap_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign swap_ack  = r_swap_ack;
    assign buf_sel   = r_buf_sel;
    assign mem_en    = r_mem_en;
    assign mem_addr  = r_mem_addr;
    assign hsync_out = r_hsync;
    assign vsync_out = r_vsync;
    assign rgb       = r_rgb;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: reset flush, addressing, window/border,
// sync/data alignment and the buffer-swap handshake.
module tb_vga_frame_reader;

    localparam logic [11:0] BORDER_C = 12'h0F0;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_stb;
    logic        hsync_in;
    logic        vsync_in;
    logic        active_in;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        screenend;
    logic        swap_req;
    logic        swap_ack;
    logic        buf_sel;
    logic        mem_en;
    logic [16:0] mem_addr;
    logic [11:0] mem_rdata;
    logic        hsync_out;
    logic        vsync_out;
    logic [11:0] rgb;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_frame_reader #(
        .BORDER (BORDER_C)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_stb   (pix_stb),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .active_in (active_in),
        .x         (x),
        .y         (y),
        .screenend (screenend),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .buf_sel   (buf_sel),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .rgb       (rgb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One idle clk followed by one strobe clk; outputs sampled 1ns after the strobe edge
    task automatic tk();
        pix_stb = 1'b0;
        @(posedge clk); #1;
        pix_stb = 1'b1;
        @(posedge clk); #1;
        pix_stb = 1'b0;
    endtask

    task automatic off();
        pix_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_px(input logic hs, input logic vs, input logic act,
                          input int unsigned xx, input int unsigned yy);
        hsync_in  = hs;
        vsync_in  = vs;
        active_in = act;
        x         = 10'(xx);
        y         = 10'(yy);
    endtask

    initial begin
        reset     = 1'b1;
        pix_stb   = 1'b0;
        screenend = 1'b0;
        swap_req  = 1'b0;
        mem_rdata = 12'hABC;
        set_px(1'b1, 1'b1, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hsync", 32'(hsync_out), 32'd1);
        check("rst_vsync", 32'(vsync_out), 32'd1);
        check("rst_rgb",   32'(rgb),       32'h0);
        check("rst_memen", 32'(mem_en),    32'd0);
        check("rst_addr",  32'(mem_addr),  32'h0);
        check("rst_buf",   32'(buf_sel),   32'd0);
        check("rst_ack",   32'(swap_ack),  32'd0);
        reset = 1'b0;

        // Fill the pipe with in-window pixels and low syncs, then reset mid-line
        set_px(1'b0, 1'b0, 1'b1, 300, 200);
        repeat (3) tk();
        check("warm_hsync", 32'(hsync_out), 32'd0);
        check("warm_rgb",   32'(rgb),       32'hABC);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("flush_hsync0", 32'(hsync_out), 32'd1);
        check("flush_vsync0", 32'(vsync_out), 32'd1);
        check("flush_rgb0",   32'(rgb),       32'h0);
        check("flush_memen0", 32'(mem_en),    32'd0);
        tk();
        check("flush_hsync1", 32'(hsync_out), 32'd1);
        check("flush_rgb1",   32'(rgb),       32'h0);
        tk();
        check("flush_hsync2", 32'(hsync_out), 32'd1);
        check("flush_vsync2", 32'(vsync_out), 32'd1);
        check("flush_rgb2",   32'(rgb),       32'h0);
        tk();
        check("resume_hsync", 32'(hsync_out), 32'd0);
        check("resume_rgb",   32'(rgb),       32'hABC);

        // Address generation, upscale by 2
        set_px(1'b1, 1'b1, 1'b1, 256, 128); tk();
        check("addr_x256_en", 32'(mem_en),   32'd1);
        check("addr_x256",    32'(mem_addr), 32'h00000);
        set_px(1'b1, 1'b1, 1'b1, 257, 128); tk();
        check("addr_x257",    32'(mem_addr), 32'h00000);
        set_px(1'b1, 1'b1, 1'b1, 258, 128); tk();
        check("addr_x258",    32'(mem_addr), 32'h00001);
        set_px(1'b1, 1'b1, 1'b1, 256, 130); tk();
        check("addr_y130",    32'(mem_addr), 32'h00100);
        set_px(1'b1, 1'b1, 1'b1, 767, 130); tk();
        check("addr_x767_en", 32'(mem_en),   32'd1);
        check("addr_x767",    32'(mem_addr), 32'h001FF);
        off();
        check("memen_nostb",  32'(mem_en),   32'd0);
        check("addr_hold",    32'(mem_addr), 32'h001FF);

        // Window edges: border outside, black when inactive
        set_px(1'b1, 1'b1, 1'b1, 255, 200); tk();
        check("x255_en",   32'(mem_en),   32'd0);
        check("x255_addr", 32'(mem_addr), 32'h001FF);
        tk(); tk();
        check("x255_rgb",  32'(rgb),      32'(BORDER_C));
        set_px(1'b1, 1'b1, 1'b1, 768, 200); tk();
        check("x768_en",   32'(mem_en),   32'd0);
        tk(); tk();
        check("x768_rgb",  32'(rgb),      32'(BORDER_C));
        set_px(1'b1, 1'b1, 1'b1, 300, 127); tk();
        check("y127_en",   32'(mem_en),   32'd0);
        set_px(1'b1, 1'b1, 1'b1, 300, 640); tk();
        check("y640_en",   32'(mem_en),   32'd0);
        set_px(1'b1, 1'b1, 1'b1, 300, 639); tk();
        check("y639_en",   32'(mem_en),   32'd1);
        set_px(1'b1, 1'b1, 1'b0, 300, 200); tk();
        check("inact_en",  32'(mem_en),   32'd0);
        tk(); tk();
        check("inact_rgb", 32'(rgb),      32'h0);

        // Sync/data alignment: hsync falls with the first window pixel
        set_px(1'b0, 1'b0, 1'b1, 400, 300); tk();
        check("align_hs_t0",  32'(hsync_out), 32'd1);
        check("align_rgb_t0", 32'(rgb),       32'h0);
        set_px(1'b1, 1'b1, 1'b0, 400, 300); tk();
        check("align_hs_t1",  32'(hsync_out), 32'd1);
        check("align_rgb_t1", 32'(rgb),       32'h0);
        tk();
        check("align_hs_t2",  32'(hsync_out), 32'd0);
        check("align_vs_t2",  32'(vsync_out), 32'd0);
        check("align_rgb_t2", 32'(rgb),       32'hABC);
        tk();
        check("align_hs_t3",  32'(hsync_out), 32'd1);

        // Swap requested mid-frame, honoured only at screenend
        set_px(1'b1, 1'b1, 1'b1, 300, 300);
        swap_req = 1'b1;
        tk(); tk();
        check("pend_ack", 32'(swap_ack), 32'd0);
        check("pend_buf", 32'(buf_sel),  32'd0);
        screenend = 1'b1; off(); off();
        check("pend_nostb_buf", 32'(buf_sel), 32'd0);
        tk();
        screenend = 1'b0;
        check("swap_ack", 32'(swap_ack), 32'd1);
        check("swap_buf", 32'(buf_sel),  32'd1);
        off();
        check("swap_ack_pulse", 32'(swap_ack), 32'd0);
        set_px(1'b1, 1'b1, 1'b1, 256, 128); tk();
        check("newbuf_addr", 32'(mem_addr), 32'h10000);
        screenend = 1'b1; tk(); screenend = 1'b0;
        check("held_ack", 32'(swap_ack), 32'd0);
        check("held_buf", 32'(buf_sel),  32'd1);
        swap_req = 1'b0; tk();

        // Request raised on the very screenend strobe edge
        off();
        pix_stb   = 1'b1;
        swap_req  = 1'b1;
        screenend = 1'b1;
        @(posedge clk); #1;
        pix_stb   = 1'b0;
        screenend = 1'b0;
        check("imm_ack", 32'(swap_ack), 32'd1);
        check("imm_buf", 32'(buf_sel),  32'd0);
        off();
        check("imm_ack_pulse", 32'(swap_ack), 32'd0);
        swap_req = 1'b0; tk();

        // Request dropped while pending: no swap
        swap_req = 1'b1; tk();
        swap_req = 1'b0; tk();
        screenend = 1'b1; tk(); screenend = 1'b0;
        check("abort_ack", 32'(swap_ack), 32'd0);
        check("abort_buf", 32'(buf_sel),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
